// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared state type, defaults and pointer wrap helper for rr_arbiter_n
package rr_arb_pkg;

  typedef enum logic {IDLE, GRANTED} rr_state_t;

  localparam int unsigned RR_N_DEFAULT        = 4;
  localparam int unsigned RR_MAX_HOLD_DEFAULT = 16;

  // Wraps at n, which need not be a power of two.
  function automatic int unsigned rr_wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - combinational rotating-priority pick: first set req bit at or after ptr, wrapping at N
module rr_priority_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDXW = $clog2(N)
) (
  input  logic [N-1:0]    i_req,
  input  logic [IDXW-1:0] i_ptr,
  output logic [N-1:0]    o_onehot,
  output logic [IDXW-1:0] o_idx,
  output logic            o_any
);

  localparam logic [IDXW:0] W_N = (IDXW+1)'(N);

  logic [IDXW:0]   w_sum;
  logic [IDXW-1:0] w_cand;

  // Scan from the lowest priority back to the highest so the last hit wins.
  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_sum    = '0;
    w_cand   = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_sum = {1'b0, i_ptr} + (IDXW+1)'(k);
      if (w_sum >= W_N) begin
        w_sum = w_sum - W_N;
      end
      w_cand = w_sum[IDXW-1:0];
      if (i_req[w_cand]) begin
        o_onehot         = '0;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
        o_any            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_n.sv
// rtl/rr_arbiter_n.sv - N-way round-robin arbiter with held one-hot grant and back-to-back re-arbitration
// Optional hold-timeout watchdog enabled by defining RR_TIMEOUT_EN.
module rr_arbiter_n
  import rr_arb_pkg::*;
#(
  parameter int unsigned N        = RR_N_DEFAULT,
  parameter int unsigned IDXW     = $clog2(N),
  parameter int unsigned MAX_HOLD = RR_MAX_HOLD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [N-1:0]    req,
  input  logic            grant_ack,
  output logic [N-1:0]    grant_vector,
  output logic [IDXW-1:0] grant_index,
  output logic            grant_valid,
  output logic            timeout
);

  if (N < 2 || N > 32) begin : g_bad_n
    $error("rr_arbiter_n: N must be in 2..32");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("rr_arbiter_n: MAX_HOLD must be at least 1");
  end

  rr_state_t       r_state, w_state_nxt;
  logic [IDXW-1:0] r_ptr, w_ptr_nxt;
  logic [N-1:0]    r_vec, w_vec_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt;
  logic            r_valid, w_valid_nxt;
  logic            r_timeout, w_timeout_nxt;

  logic [IDXW-1:0] w_ptr_inc;
  logic [IDXW-1:0] w_pick_ptr;
  logic [N-1:0]    w_pick_vec;
  logic [IDXW-1:0] w_pick_idx;
  logic            w_pick_any;
  logic            w_done;
  logic            w_revoke;

  assign w_ptr_inc  = IDXW'(rr_wrap_inc(32'(r_idx), N));
  // On completion the pick must already see the advanced pointer for a bubble-free handoff.
  assign w_pick_ptr = (r_state == GRANTED) ? w_ptr_inc : r_ptr;
  assign w_done     = (r_state == GRANTED) && (grant_ack || !req[r_idx]);

  rr_priority_pick #(
    .N    (N),
    .IDXW (IDXW)
  ) u_pick (
    .i_req    (req),
    .i_ptr    (w_pick_ptr),
    .o_onehot (w_pick_vec),
    .o_idx    (w_pick_idx),
    .o_any    (w_pick_any)
  );

`ifdef RR_TIMEOUT_EN
  localparam int unsigned HW = $clog2(MAX_HOLD) + 1;

  logic [HW-1:0] r_hold, w_hold_nxt;

  assign w_revoke = (r_state == GRANTED) && !w_done && (r_hold == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else begin
      r_hold <= w_hold_nxt;
    end
  end

  always_comb begin
    w_hold_nxt = r_hold;
    if (r_state == IDLE) begin
      w_hold_nxt = '0;
    end else if (!w_done && !w_revoke) begin
      w_hold_nxt = r_hold + HW'(1);
    end else begin
      w_hold_nxt = '0;
    end
  end
`else
  assign w_revoke = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_vec     <= '0;
      r_idx     <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_vec     <= w_vec_nxt;
      r_idx     <= w_idx_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_vec_nxt     = r_vec;
    w_idx_nxt     = r_idx;
    w_valid_nxt   = r_valid;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_pick_any) begin
          w_state_nxt = GRANTED;
          w_vec_nxt   = w_pick_vec;
          w_idx_nxt   = w_pick_idx;
          w_valid_nxt = 1'b1;
        end else begin
          w_vec_nxt   = '0;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      end
      GRANTED: begin
        // A real completion wins over a same-edge watchdog expiry.
        if (w_done || w_revoke) begin
          w_ptr_nxt     = w_ptr_inc;
          w_timeout_nxt = w_revoke;
          if (enable && w_pick_any) begin
            w_vec_nxt   = w_pick_vec;
            w_idx_nxt   = w_pick_idx;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = IDLE;
            w_vec_nxt   = '0;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_vec_nxt   = '0;
        w_idx_nxt   = '0;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  assign grant_vector = r_vec;
  assign grant_index  = r_idx;
  assign grant_valid  = r_valid;
  assign timeout      = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_n.sv
// tb/tb_rr_arbiter_n.sv - scoreboard bench for rr_arbiter_n (N=5) against a behavioural round-robin model
module tb_rr_arbiter_n;

  localparam int N        = 5;
  localparam int IDXW     = $clog2(N);
  localparam int MAX_HOLD = 4;
`ifdef RR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n;
  logic            enable;
  logic [N-1:0]    req;
  logic            grant_ack;
  logic [N-1:0]    grant_vector;
  logic [IDXW-1:0] grant_index;
  logic            grant_valid;
  logic            timeout;

  rr_arbiter_n #(
    .N        (N),
    .IDXW     (IDXW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .req          (req),
    .grant_ack    (grant_ack),
    .grant_vector (grant_vector),
    .grant_index  (grant_index),
    .grant_valid  (grant_valid),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]    vec;
    logic [IDXW-1:0] idx;
    logic            valid;
    logic            to;
  } exp_t;

  typedef struct {
    bit           en;
    logic [N-1:0] r;
    bit           ack;
  } stim_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_timeouts = 0;

  bit m_valid;
  int m_idx;
  int m_ptr;
  int m_hold;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requester order starting at p, wrapping modulo N.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 0;
    m_ptr   = 0;
    m_hold  = 0;
  endtask

  function automatic exp_t model_out(input bit to);
    exp_t e;
    e.vec   = m_valid ? (N'(1) << m_idx) : '0;
    e.idx   = IDXW'(m_idx);
    e.valid = m_valid;
    e.to    = to;
    return e;
  endfunction

  // Called at a falling edge: drive inputs, advance the model to the next rising edge, queue the result.
  task automatic step(input bit en, input logic [N-1:0] r, input bit ack);
    bit to;
    bit done;
    bit rev;
    enable    = en;
    req       = r;
    grant_ack = ack;
    to = 1'b0;
    if (!m_valid) begin
      if (en && r != '0) begin
        m_idx   = pick(r, m_ptr);
        m_valid = 1'b1;
        m_hold  = 0;
      end
    end else begin
      done = ack || !r[m_idx];
      rev  = TO_EN && !done && (m_hold == MAX_HOLD - 1);
      if (done || rev) begin
        m_ptr = (m_idx + 1) % N;
        to    = rev;
        if (en && r != '0) begin
          m_idx  = pick(r, m_ptr);
          m_hold = 0;
        end else begin
          m_valid = 1'b0;
          m_idx   = 0;
        end
      end else begin
        m_hold++;
      end
    end
    sb_q.push_back(model_out(to));
    @(negedge clk);
  endtask

  task automatic reset_mid_run();
    reset_n = 1'b0;
    #1;
    check("async_reset_vector", 32'(grant_vector), 32'd0);
    check("async_reset_valid", 32'(grant_valid), 32'd0);
    check("async_reset_index", 32'(grant_index), 32'd0);
    model_reset();
    sb_q.push_back(model_out(1'b0));
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("grant_vector", 32'(grant_vector), 32'(e.vec));
      check("grant_index", 32'(grant_index), 32'(e.idx));
      check("grant_valid", 32'(grant_valid), 32'(e.valid));
      check("timeout", 32'(timeout), 32'(e.to));
      if (timeout) n_timeouts++;
    end
    check("onehot0", 32'($onehot0(grant_vector)), 32'd1);
    check("vec_at_index", 32'(grant_vector[grant_index]), 32'(grant_valid));
  end

  stim_t dir[$];

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: got running expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    logic [N-1:0] r;
    reset_n   = 1'b0;
    enable    = 1'b0;
    req       = '0;
    grant_ack = 1'b0;
    model_reset();
    #1;
    check("reset_vector", 32'(grant_vector), 32'd0);
    check("reset_index", 32'(grant_index), 32'd0);
    check("reset_valid", 32'(grant_valid), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Rotation, abandon, enable-low hold, wrap at N=5, long hold for the watchdog.
    dir.push_back('{1'b1, 5'b11111, 1'b0});
    repeat (6) dir.push_back('{1'b1, 5'b11111, 1'b1});
    dir.push_back('{1'b1, 5'b11101, 1'b0});
    dir.push_back('{1'b1, 5'b00000, 1'b0});
    dir.push_back('{1'b1, 5'b00000, 1'b0});
    dir.push_back('{1'b1, 5'b00100, 1'b0});
    dir.push_back('{1'b0, 5'b11111, 1'b0});
    dir.push_back('{1'b0, 5'b11111, 1'b0});
    dir.push_back('{1'b0, 5'b11111, 1'b1});
    dir.push_back('{1'b0, 5'b11111, 1'b0});
    dir.push_back('{1'b1, 5'b11001, 1'b0});
    dir.push_back('{1'b1, 5'b10001, 1'b1});
    dir.push_back('{1'b1, 5'b10001, 1'b1});
    dir.push_back('{1'b1, 5'b11111, 1'b1});
    repeat (9) dir.push_back('{1'b1, 5'b11111, 1'b0});
    dir.push_back('{1'b1, 5'b11111, 1'b1});
    repeat (3) dir.push_back('{1'b1, 5'b11111, 1'b0});
    dir.push_back('{1'b1, 5'b11111, 1'b1});
    foreach (dir[i]) step(dir[i].en, dir[i].r, dir[i].ack);

    reset_mid_run();
    step(1'b1, 5'b11111, 1'b0);

    for (int c = 0; c < 1500; c++) begin
      if (c == 700) reset_mid_run();
      step(($urandom % 8) != 0, N'($urandom), ($urandom % 4) == 0);
    end
    for (int c = 0; c < 1000; c++) begin
      r = '0;
      for (int b = 0; b < N; b++) r[b] = ($urandom % 8) != 0;
      step(($urandom % 16) != 0, r, ($urandom % 16) == 0);
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    if (TO_EN) check("watchdog_exercised", 32'(n_timeouts > 0), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
